branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Two-stage pipelined branch/compare resolver sitting directly downstream of comparator_16bit in the execute path.
- Registers branch operands and drives them to an external comparator_16bit instance. Captures its lt/gt/eq result and applies signed correction. Evaluates the branch condition and produces taken, next-PC and mispredict to fetch over a valid/ready handshake.
- Also holds a persistent architectural flag register (LT/GT/EQ, signed-corrected) for later conditional ops.

Parameters:
- W, 16, operand/PC width; must match the comparator width.
- OFF_W, 8, branch offset width; sign-extended to W.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of both pipeline stages.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_cond  input  3  condition code: 0 EQ, 1 NE, 2 LT, 3 GE, 4 LTU, 5 GEU, 6 GT, 7 LE.
- in_pc  input  W  branch instruction PC (word address).
- in_off  input  OFF_W  signed branch offset.
- in_pred  input  1  fetch prediction (1 = taken).
- cmp_a  output  W  to comparator inp1; equals the S1 operand A register.
- cmp_b  output  W  to comparator inp2; equals the S1 operand B register.
- cmp_lt, cmp_gt, cmp_eq  input  1 each  unsigned result from the comparator, combinational within the same cycle.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer ready.
- out_taken  output  1  resolved direction.
- out_next_pc  output  W  resolved next PC.
- out_mispredict  output  1  out_taken != pred of that branch.
- flags  output  3  {lt,gt,eq} of the last retired compare, signed-corrected.

Behaviour:
- Reset (async, rst_n=0) clears:
  - s1_valid=0, s2_valid=0, out_valid=0.
  - out_taken=0, out_next_pc=0, out_mispredict=0.
  - flags=3'b001.
  - cmp_a=0, cmp_b=0.
- Reset mid-operation discards in-flight requests; no output is produced for them after release.
- Stage S1 registers a, b, cond, pc, off, pred on accept; cmp_a/cmp_b are driven from these registers.
- Stage S2 registers the evaluated result and drives the out_* ports.
- Latency: accept in cycle N gives out_valid in cycle N+2 when there is no backpressure.
- Throughput: one request per cycle.
- Handshake and advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_adv.
  - in_ready = !s1_valid || s2_adv. in_ready is combinational on out_ready; there is no comb path from in_valid.
- Backpressure: while out_valid && !out_ready, all out_* ports hold stable and S1 holds.
- Signed correction is applied in S1's cycle:
  - If a[W-1] != b[W-1]: slt = a[W-1], sgt = b[W-1].
  - Otherwise: slt = cmp_lt, sgt = cmp_gt.
  - eq = cmp_eq in both cases.
- Condition evaluation:
  - EQ: eq. NE: !eq.
  - LT: slt. GE: !slt.
  - LTU: cmp_lt. GEU: !cmp_lt.
  - GT: sgt. LE: !sgt.
- Next PC:
  - taken: pc + sign_ext(off).
  - not taken: pc + 1.
  - Arithmetic is modulo 2^W; wrap-around is silent.
- flags updates to {slt, sgt, eq} when a result is retired (out_valid && out_ready). Flags always use the signed-corrected values, whatever the condition code.
- flush=1 clears s1_valid and s2_valid on the next edge. A request presented in the same cycle as flush is not accepted, and in_ready=0 while flush=1.
- flush does not alter flags, except that a result retiring in the same cycle still updates flags.
- Simultaneous S2 retire and S1 advance in one cycle is legal; no bubble is inserted.

Test Plan:
- Reset then a=0x0005, b=0x0005, cond EQ, pc=0x0100, off=0x04, pred=0 -> out_valid at cycle +2, taken=1, next_pc=0x0104, mispredict=1, flags=001.
- Signed vs unsigned, a=0xFFFF, b=0x0001:
  - cond LT -> taken=1, flags=100.
  - cond LTU -> taken=0, next_pc=pc+1.
- Wrap: pc=0xFFFE, off=0x05, a=3, b=2, cond GT -> next_pc=0x0003.
- Negative offset: pc=0x0010, off=0xF0 (-16), cond GE, taken -> next_pc=0x0000.
- Backpressure: 4 back-to-back requests with out_ready=0 for 3 cycles -> out_* stable and in_ready=0 once both stages are full. The 4 results then retire in order with no loss or duplication.
- Flush with both stages full plus in_valid in the same cycle -> no out_valid the next cycle, that request is not accepted, and flags are unchanged.
- rst_n asserted asynchronously mid-stall -> all outputs return to reset values immediately, with no output after release.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// Request/response and comparator-side signals of the branch resolver.
// The master side is the upstream issue logic plus comparator; the slave side is the resolver.
interface branch_resolve_unit_if #(
    parameter int W     = 16,
    parameter int OFF_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [2:0]       in_cond;
    logic [W-1:0]     in_pc;
    logic [OFF_W-1:0] in_off;
    logic             in_pred;

    logic [W-1:0]     cmp_a;
    logic [W-1:0]     cmp_b;
    logic             cmp_lt;
    logic             cmp_gt;
    logic             cmp_eq;

    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic [W-1:0]     out_next_pc;
    logic             out_mispredict;
    logic [2:0]       flags;

    modport master (
        output in_valid, in_a, in_b, in_cond, in_pc, in_off, in_pred,
        output cmp_lt, cmp_gt, cmp_eq, out_ready,
        input  in_ready, cmp_a, cmp_b,
        input  out_valid, out_taken, out_next_pc, out_mispredict, flags
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cond, in_pc, in_off, in_pred,
        input  cmp_lt, cmp_gt, cmp_eq, out_ready,
        output in_ready, cmp_a, cmp_b,
        output out_valid, out_taken, out_next_pc, out_mispredict, flags
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolver: S1 holds operands for the external unsigned comparator,
// S2 holds the resolved direction/next-PC; a flag register tracks the last retired compare.
module branch_resolve_unit #(
    parameter int W     = 16,
    parameter int OFF_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    branch_resolve_unit_if.slave bus
);

    localparam logic [2:0] C_EQ  = 3'd0;
    localparam logic [2:0] C_NE  = 3'd1;
    localparam logic [2:0] C_LT  = 3'd2;
    localparam logic [2:0] C_GE  = 3'd3;
    localparam logic [2:0] C_LTU = 3'd4;
    localparam logic [2:0] C_GEU = 3'd5;
    localparam logic [2:0] C_GT  = 3'd6;

    // The comparator is unsigned; when the signs differ the sign bits alone decide order.
    function automatic logic [2:0] correct_flags(input logic sa, input logic sb,
                                                 input logic lt, input logic gt,
                                                 input logic eq);
        if (sa != sb)
            return {sa, sb, eq};
        return {lt, gt, eq};
    endfunction

    function automatic logic cond_eval(input logic [2:0] cond, input logic [2:0] f,
                                       input logic ult);
        case (cond)
            C_EQ:    return f[0];
            C_NE:    return !f[0];
            C_LT:    return f[2];
            C_GE:    return !f[2];
            C_LTU:   return ult;
            C_GEU:   return !ult;
            C_GT:    return f[1];
            default: return !f[1];
        endcase
    endfunction

    function automatic logic [W-1:0] resolve_pc(input logic [W-1:0] pc,
                                                input logic signed [OFF_W-1:0] off,
                                                input logic taken);
        logic [W-1:0] step;
        step = taken ? {{(W-OFF_W){off[OFF_W-1]}}, off} : W'(1);
        return pc + step;
    endfunction

    logic                    vld_p1, vld_p2;
    logic signed [W-1:0]     a_p1, b_p1;
    logic [2:0]              cond_p1;
    logic [W-1:0]            pc_p1;
    logic signed [OFF_W-1:0] off_p1;
    logic                    pred_p1;

    logic [2:0]              flg_p1;
    logic                    taken_p1;
    logic [W-1:0]            npc_p1;

    logic                    taken_p2;
    logic [W-1:0]            npc_p2;
    logic                    mis_p2;
    logic [2:0]              flg_p2;
    logic [2:0]              flags_q;

    logic s2_adv, s1_adv, accept, retire;

    assign s2_adv       = !vld_p2 || bus.out_ready;
    assign s1_adv       = vld_p1 && s2_adv;
    assign bus.in_ready = !flush && (!vld_p1 || s2_adv);
    assign accept       = bus.in_valid && bus.in_ready;
    assign retire       = vld_p2 && bus.out_ready;

    // ---- stage p1: operand capture, comparator drive, evaluation ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p1 <= '0;
            b_p1 <= '0;
        end else if (accept) begin
            a_p1 <= $signed(bus.in_a);
            b_p1 <= $signed(bus.in_b);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cond_p1 <= bus.in_cond;
            pc_p1   <= bus.in_pc;
            off_p1  <= $signed(bus.in_off);
            pred_p1 <= bus.in_pred;
        end
    end

    assign bus.cmp_a = a_p1;
    assign bus.cmp_b = b_p1;

    assign flg_p1   = correct_flags(a_p1[W-1], b_p1[W-1], bus.cmp_lt, bus.cmp_gt, bus.cmp_eq);
    assign taken_p1 = cond_eval(cond_p1, flg_p1, bus.cmp_lt);
    assign npc_p1   = resolve_pc(pc_p1, off_p1, taken_p1);

    // ---- stage p2: resolved result toward fetch ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_p2 <= 1'b0;
            npc_p2   <= '0;
            mis_p2   <= 1'b0;
        end else if (s1_adv) begin
            taken_p2 <= taken_p1;
            npc_p2   <= npc_p1;
            mis_p2   <= taken_p1 != pred_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_adv)
            flg_p2 <= flg_p1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            flags_q <= 3'b001;
        end else begin
            if (flush)
                vld_p1 <= 1'b0;
            else if (accept)
                vld_p1 <= 1'b1;
            else if (s1_adv)
                vld_p1 <= 1'b0;

            if (flush)
                vld_p2 <= 1'b0;
            else if (s2_adv)
                vld_p2 <= vld_p1;

            // A result retiring under flush still counts as architecturally complete.
            if (retire)
                flags_q <= flg_p2;
        end
    end

    assign bus.out_valid      = vld_p2;
    assign bus.out_taken      = taken_p2;
    assign bus.out_next_pc    = npc_p2;
    assign bus.out_mispredict = mis_p2;
    assign bus.flags          = flags_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed cases plus random traffic against a queue-based model.
module tb_branch_resolve_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.W(16), .OFF_W(8)) bus ();

    // Behavioural stand-in for the external comparator_16bit.
    assign bus.cmp_lt = bus.cmp_a < bus.cmp_b;
    assign bus.cmp_gt = bus.cmp_a > bus.cmp_b;
    assign bus.cmp_eq = bus.cmp_a == bus.cmp_b;

    branch_resolve_unit #(.W(16), .OFF_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic        taken;
        logic [15:0] npc;
        logic        mis;
        logic [2:0]  flg;
        int          acc;
    } exp_t;

    exp_t       q[$];
    logic [2:0] mflags = 3'b001;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic       last_acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic [2:0] c, input logic [15:0] pc,
                                   input logic [7:0] off, input logic pred);
        exp_t e;
        int   sa, sb, so;
        logic t;
        sa = $signed(a);
        sb = $signed(b);
        so = $signed(off);
        e.flg = {sa < sb, sa > sb, a == b};
        case (c)
            3'd0:    t = (a == b);
            3'd1:    t = (a != b);
            3'd2:    t = (sa < sb);
            3'd3:    t = (sa >= sb);
            3'd4:    t = (a < b);
            3'd5:    t = (a >= b);
            3'd6:    t = (sa > sb);
            default: t = (sa <= sb);
        endcase
        e.taken = t;
        e.npc   = 16'(int'(pc) + (t ? so : 1));
        e.mis   = (t != pred);
        e.acc   = 0;
        return e;
    endfunction

    task automatic tick();
        logic ev, er, acc, ret;
        exp_t e;
        @(negedge clk);
        ev = (q.size() == 2) || (q.size() == 1 && (cyc - q[0].acc) >= 1);
        er = !flush && (q.size() < 2 || bus.out_ready);
        chk("out_valid", 32'(bus.out_valid), 32'(ev));
        chk("in_ready", 32'(bus.in_ready), 32'(er));
        chk("flags", 32'(bus.flags), 32'(mflags));
        if (ev) begin
            chk("taken", 32'(bus.out_taken), 32'(q[0].taken));
            chk("next_pc", 32'(bus.out_next_pc), 32'(q[0].npc));
            chk("mispredict", 32'(bus.out_mispredict), 32'(q[0].mis));
        end
        ret = ev && bus.out_ready;
        acc = bus.in_valid && er;
        e = model(bus.in_a, bus.in_b, bus.in_cond, bus.in_pc, bus.in_off, bus.in_pred);
        @(posedge clk);
        cyc++;
        if (ret) begin
            mflags = q[0].flg;
            void'(q.pop_front());
        end
        if (flush)
            q.delete();
        else if (acc) begin
            e.acc = cyc;
            q.push_back(e);
        end
        last_acc = acc;
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c,
                        input logic [15:0] pc, input logic [7:0] off, input logic p);
        bus.in_a = a; bus.in_b = b; bus.in_cond = c;
        bus.in_pc = pc; bus.in_off = off; bus.in_pred = p;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_acc) break;
        end
        if (!last_acc) chk("send_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic directed(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c,
                            input logic [15:0] pc, input logic [7:0] off, input logic p,
                            input logic et, input logic [15:0] enpc, input logic [2:0] ef);
        send(a, b, c, pc, off, p);
        tick();
        chk("dir_valid", 32'(bus.out_valid), 32'd1);
        chk("dir_taken", 32'(bus.out_taken), 32'(et));
        chk("dir_next_pc", 32'(bus.out_next_pc), 32'(enpc));
        tick();
        chk("dir_flags", 32'(bus.flags), 32'(ef));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] saved;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cond = '0;
        bus.in_pc = '0; bus.in_off = '0; bus.in_pred = 1'b0; bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_taken", 32'(bus.out_taken), 32'd0);
        chk("rst_next_pc", 32'(bus.out_next_pc), 32'd0);
        chk("rst_mispredict", 32'(bus.out_mispredict), 32'd0);
        chk("rst_flags", 32'(bus.flags), 32'b001);
        chk("rst_cmp_a", 32'(bus.cmp_a), 32'd0);
        chk("rst_cmp_b", 32'(bus.cmp_b), 32'd0);
        rst_n = 1'b1;
        tick();

        directed(16'h0005, 16'h0005, 3'd0, 16'h0100, 8'h04, 1'b0, 1'b1, 16'h0104, 3'b001);
        directed(16'hFFFF, 16'h0001, 3'd2, 16'h0200, 8'h10, 1'b0, 1'b1, 16'h0210, 3'b100);
        directed(16'hFFFF, 16'h0001, 3'd4, 16'h0200, 8'h10, 1'b0, 1'b0, 16'h0201, 3'b100);
        directed(16'h0003, 16'h0002, 3'd6, 16'hFFFE, 8'h05, 1'b1, 1'b1, 16'h0003, 3'b010);
        directed(16'h0002, 16'h0002, 3'd3, 16'h0010, 8'hF0, 1'b1, 1'b1, 16'h0000, 3'b001);

        // Backpressure: two requests fill the pipe, a third waits three stalled cycles.
        bus.out_ready = 1'b0;
        send(16'h0001, 16'h0002, 3'd2, 16'h0300, 8'h08, 1'b1);
        send(16'h8000, 16'h7FFF, 3'd6, 16'h0400, 8'h80, 1'b0);
        bus.in_a = 16'h0007; bus.in_b = 16'h0007; bus.in_cond = 3'd1;
        bus.in_pc = 16'h0500; bus.in_off = 8'h02; bus.in_pred = 1'b0;
        bus.in_valid = 1'b1;
        repeat (3) begin
            tick();
            chk("bp_not_accepted", 32'(last_acc), 32'd0);
        end
        bus.out_ready = 1'b1;
        send(16'h0007, 16'h0007, 3'd1, 16'h0500, 8'h02, 1'b0);
        send(16'h1234, 16'hFEDC, 3'd5, 16'h0600, 8'h7F, 1'b1);
        repeat (4) tick();
        chk("bp_drained", 32'(q.size()), 32'd0);

        // Flush with both stages full and a new request in the same cycle.
        bus.out_ready = 1'b0;
        send(16'h0010, 16'h0020, 3'd7, 16'h0700, 8'h03, 1'b0);
        send(16'h0030, 16'h0020, 3'd0, 16'h0800, 8'h04, 1'b1);
        saved = bus.flags;
        bus.in_a = 16'h0001; bus.in_b = 16'h0001; bus.in_cond = 3'd0;
        bus.in_valid = 1'b1;
        flush = 1'b1;
        tick();
        chk("flush_no_accept", 32'(last_acc), 32'd0);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_flags", 32'(bus.flags), 32'(saved));
        bus.out_ready = 1'b1;
        repeat (3) tick();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            bus.in_a      = 16'($urandom);
            bus.in_b      = ($urandom_range(0, 3) == 0) ? bus.in_a : 16'($urandom);
            bus.in_cond   = 3'($urandom);
            bus.in_pc     = 16'($urandom);
            bus.in_off    = 8'($urandom);
            bus.in_pred   = 1'($urandom);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            flush         = ($urandom_range(0, 24) == 0);
            tick();
        end
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();

        // Asynchronous reset in the middle of a stall.
        bus.out_ready = 1'b0;
        send(16'hFFFE, 16'h0003, 3'd2, 16'h0900, 8'h10, 1'b0);
        send(16'h0004, 16'h0004, 3'd0, 16'h0A00, 8'h20, 1'b1);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_taken", 32'(bus.out_taken), 32'd0);
        chk("arst_next_pc", 32'(bus.out_next_pc), 32'd0);
        chk("arst_mispredict", 32'(bus.out_mispredict), 32'd0);
        chk("arst_flags", 32'(bus.flags), 32'b001);
        chk("arst_cmp_a", 32'(bus.cmp_a), 32'd0);
        q.delete();
        mflags = 3'b001;
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
